// File: rtl/mux_sel_seq.sv
// Pattern-driven mux select sequencer: walks a programmable select table once per
// window position across a square output frame of L x L positions.
module mux_sel_seq #(
  parameter  int SEL_W  = 3,
  parameter  int DEPTH  = 16,
  parameter  int SIZE_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              cfg_we_i,
  input  logic [AW-1:0]     cfg_addr_i,
  input  logic [SEL_W-1:0]  cfg_data_i,
  input  logic [AW:0]       pat_len_i,
  input  logic [SIZE_W-1:0] pic_size_i,
  input  logic [3:0]        ksize_i,
  input  logic              padding_i,
  input  logic              start_i,
  input  logic              ctrl_update_i,
  input  logic              ctrl_reset_i,
  output logic [SEL_W-1:0]  ctrl_sel_o,
  output logic              line_end_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = SIZE_W + 1;
  localparam int LW = SIZE_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     line_q, line_d;
  logic [AW:0]       plen_q, plen_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              line_end_q, line_end_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  tbl_q [DEPTH];

  logic [LW-1:0]     line_len_s;
  logic              start_ok_s;
  logic              col_last_s;
  logic              row_last_s;
  logic              ptr_last_s;

  // Two extra bits keep the subtraction signed without overflow for any pic/ksize mix.
  assign line_len_s = LW'(pic_size_i) - LW'(ksize_i) + LW'(1'b1) + LW'({padding_i, 1'b0});
  assign start_ok_s = !line_len_s[LW-1] && (line_len_s != '0) &&
                      (pat_len_i != '0) && (pat_len_i <= (AW+1)'(DEPTH));
  assign col_last_s = (col_q == line_q - CW'(1'b1));
  assign row_last_s = (row_q == line_q - CW'(1'b1));
  assign ptr_last_s = ({1'b0, ptr_q} == plen_q - (AW+1)'(1'b1));

  // Pattern table: writable only while idle and deliberately kept across reset.
  always_ff @(posedge SYS_CLK) begin
    if (cfg_we_i && (state_q == IDLE)) begin
      tbl_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  // State and counter registers.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      line_q     <= '0;
      plen_q     <= '0;
      ptr_q      <= '0;
      line_end_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      line_q     <= line_d;
      plen_q     <= plen_d;
      ptr_q      <= ptr_d;
      line_end_q <= line_end_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    line_d     = line_q;
    plen_d     = plen_q;
    ptr_d      = ptr_q;
    line_end_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok_s) begin
            line_d  = line_len_s[CW-1:0];
            plen_d  = pat_len_i;
            col_d   = '0;
            row_d   = '0;
            ptr_d   = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A restart request takes priority and suppresses the advance.
        if (ctrl_reset_i) begin
          ptr_d = '0;
          col_d = '0;
        end else if (ctrl_update_i) begin
          if (col_last_s) begin
            col_d      = '0;
            ptr_d      = '0;
            row_d      = row_q + CW'(1'b1);
            line_end_d = 1'b1;
            if (row_last_s) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            col_d = col_q + CW'(1'b1);
            ptr_d = ptr_last_s ? '0 : ptr_q + AW'(1'b1);
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctrl_sel_o = (state_q == RUN) ? tbl_q[ptr_q] : '0;
  assign busy_o     = (state_q == RUN);
  assign line_end_o = line_end_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: directed scenarios plus random frames against a
// position-counting reference model.
module tb_mux_sel_seq;

  localparam int SEL_W  = 3;
  localparam int DEPTH  = 16;
  localparam int SIZE_W = 8;
  localparam int AW     = 4;

  logic              SYS_CLK = 1'b0;
  logic              SYS_RST;
  logic              cfg_we_i;
  logic [AW-1:0]     cfg_addr_i;
  logic [SEL_W-1:0]  cfg_data_i;
  logic [AW:0]       pat_len_i;
  logic [SIZE_W-1:0] pic_size_i;
  logic [3:0]        ksize_i;
  logic              padding_i;
  logic              start_i;
  logic              ctrl_update_i;
  logic              ctrl_reset_i;
  logic [SEL_W-1:0]  ctrl_sel_o;
  logic              line_end_o;
  logic              done_o;
  logic              busy_o;
  logic              err_o;

  mux_sel_seq #(.SEL_W(SEL_W), .DEPTH(DEPTH), .SIZE_W(SIZE_W)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .pat_len_i(pat_len_i), .pic_size_i(pic_size_i), .ksize_i(ksize_i),
    .padding_i(padding_i), .start_i(start_i), .ctrl_update_i(ctrl_update_i),
    .ctrl_reset_i(ctrl_reset_i), .ctrl_sel_o(ctrl_sel_o), .line_end_o(line_end_o),
    .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 running, 2 done; m_pos = updates since line start.
  int m_tbl [DEPTH];
  int m_state = 0;
  int m_pos   = 0;
  int m_row   = 0;
  int m_L     = 1;
  int m_len   = 1;
  int le_cnt  = 0;
  int done_cnt = 0;
  int pic_v = 0, k_v = 1, pad_v = 0, len_v = 1, a_v = 0, d_v = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input bit e_le, input bit e_done, input bit e_err);
    int e_sel;
    e_sel = (m_state == 1) ? m_tbl[m_pos % m_len] : 0;
    chk("ctrl_sel", 32'(ctrl_sel_o), 32'(e_sel));
    chk("line_end", 32'(line_end_o), 32'(e_le));
    chk("done", 32'(done_o), 32'(e_done));
    chk("busy", 32'(busy_o), 32'(m_state == 1));
    chk("err", 32'(err_o), 32'(e_err));
  endtask

  // One clock cycle: update the model, drive the DUT, check after the edge.
  task automatic cyc(input bit st, input bit up, input bit cr, input bit we);
    int L;
    bit e_le, e_done, e_err;
    e_le = 1'b0; e_done = 1'b0; e_err = 1'b0;
    case (m_state)
      0: begin
        if (we) m_tbl[a_v] = d_v;
        if (st) begin
          L = pic_v - k_v + 1 + 2 * pad_v;
          if (L < 1 || len_v == 0 || len_v > DEPTH) begin
            e_err = 1'b1;
          end else begin
            m_L = L; m_len = len_v; m_pos = 0; m_row = 0; m_state = 1;
          end
        end
      end
      1: begin
        if (cr) begin
          m_pos = 0;
        end else if (up) begin
          m_pos++;
          if (m_pos == m_L) begin
            m_pos = 0;
            m_row++;
            e_le = 1'b1;
            if (m_row == m_L) begin
              e_done = 1'b1;
              m_state = 2;
            end
          end
        end
      end
      default: m_state = 0;
    endcase
    start_i       = st;
    ctrl_update_i = up;
    ctrl_reset_i  = cr;
    cfg_we_i      = we;
    cfg_addr_i    = a_v[AW-1:0];
    cfg_data_i    = d_v[SEL_W-1:0];
    pic_size_i    = pic_v[SIZE_W-1:0];
    ksize_i       = k_v[3:0];
    padding_i     = pad_v[0];
    pat_len_i     = len_v[AW:0];
    @(posedge SYS_CLK);
    #1;
    start_i = 1'b0; ctrl_update_i = 1'b0; ctrl_reset_i = 1'b0; cfg_we_i = 1'b0;
    if (line_end_o) le_cnt++;
    if (done_o) done_cnt++;
    chk_outputs(e_le, e_done, e_err);
  endtask

  task automatic wr(input int addr, input int data);
    a_v = addr; d_v = data;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_cfg(input int pic, input int k, input int pad, input int len);
    pic_v = pic; k_v = k; pad_v = pad; len_v = len;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 5000 && m_state != 0; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("frame_bound", 32'(m_state), 32'd0);
  endtask

  task automatic async_reset_check();
    #2 SYS_RST = 1'b1;
    #1;
    m_state = 0;
    chk_outputs(1'b0, 1'b0, 1'b0);
    #1 SYS_RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat1 [12];
    int r;
    pat1 = '{0, 1, 2, 3, 4, 5, 1, 0, 3, 2, 5, 4};
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    SYS_RST = 1'b1;
    start_i = 1'b0; ctrl_update_i = 1'b0; ctrl_reset_i = 1'b0; cfg_we_i = 1'b0;
    cfg_addr_i = '0; cfg_data_i = '0; pat_len_i = '0; pic_size_i = '0;
    ksize_i = '0; padding_i = 1'b0;
    #12;
    chk_outputs(1'b0, 1'b0, 1'b0);
    @(negedge SYS_CLK);
    SYS_RST = 1'b0;
    @(posedge SYS_CLK);
    #1;
    chk_outputs(1'b0, 1'b0, 1'b0);

    // 12-entry pattern, L=14: sequence wraps mid-line, then line_end.
    for (int i = 0; i < 12; i++) wr(i, pat1[i]);
    set_cfg(16, 3, 0, 12);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    le_cnt = 0;
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("line_end_after_14", 32'(le_cnt), 32'd1);
    // Write attempt and restart request while running are both ignored.
    a_v = 0; d_v = 7;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    run_to_idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("table0_kept", 32'(ctrl_sel_o), 32'd0);
    run_to_idle();

    // 3-entry pattern with padding, L=4: four lines, one done.
    wr(0, 0); wr(1, 3); wr(2, 4);
    set_cfg(4, 3, 1, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    le_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("line_end_count", 32'(le_cnt), 32'd4);
    chk("done_count", 32'(done_cnt), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("done_count_after", 32'(done_cnt), 32'd1);

    // Rejected starts.
    set_cfg(2, 5, 0, 3);  cyc(1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(2, 3, 0, 3);  cyc(1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8, 3, 0, 0);  cyc(1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8, 3, 0, 17); cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Smallest legal frame: L=1, one update completes it.
    set_cfg(3, 3, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Restart and update together on the last column: restart wins.
    set_cfg(5, 3, 0, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    run_to_idle();

    // Asynchronous reset mid-frame, then a fresh frame with the table intact.
    set_cfg(4, 3, 1, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    async_reset_check();
    done_cnt = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("no_done_after_reset", 32'(done_cnt), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle();

    // Random frames with random tables, configs and control traffic.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 7));
      set_cfg($urandom_range(1, 12), $urandom_range(1, 6),
              $urandom_range(0, 1), $urandom_range(0, 17));
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000 && m_state != 0; i++) begin
        r = $urandom_range(0, 99);
        a_v = $urandom_range(0, DEPTH - 1);
        d_v = $urandom_range(0, 7);
        set_cfg($urandom_range(1, 12), $urandom_range(1, 6),
                $urandom_range(0, 1), $urandom_range(0, 17));
        cyc(r < 8, r < 70, r >= 95, r >= 90 && r < 95);
      end
      if (m_state != 0) async_reset_check();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
